apb_slave: RTL and testbench

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_slave.sv | 108 ++++++++++
 tb/tb_apb_slave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/apb_slave.sv
// apb_slave: two-state transfer controller that fans a single request out to
// one of six target ports. Every output comes straight from a flop.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for en; on en=1 sample inputs into the selected port
// ACCESS | ready=1 for this single cycle, then back to IDLE
module apb_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_in,
  input  logic        en,
  input  logic [2:0]  sel_port,
  input  logic [11:0] addr_in,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        wr_out1,
  output logic        wr_out2,
  output logic        wr_out3,
  output logic        wr_out4,
  output logic        wr_out5,
  output logic        wr_out6,
  output logic [11:0] addr_out1,
  output logic [11:0] addr_out2,
  output logic [11:0] addr_out3,
  output logic [11:0] addr_out4,
  output logic [11:0] addr_out5,
  output logic [11:0] addr_out6,
  output logic [31:0] data_out1,
  output logic [31:0] data_out2,
  output logic [31:0] data_out3,
  output logic [31:0] data_out4,
  output logic [31:0] data_out5,
  output logic [31:0] data_out6
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state;
  logic        wr_q   [6];
  logic [11:0] addr_q [6];
  logic [31:0] data_q [6];

  // FSM plus per-port output registers; port registers load on the same edge
  // that moves IDLE->ACCESS, so ready and the new port values appear together.
  // Select codes 0 and 7 match no port and therefore only pulse ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ready <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        wr_q[i]   <= 1'b0;
        addr_q[i] <= 12'h000;
        data_q[i] <= 32'h0000_0000;
      end
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= ACCESS;
            ready <= 1'b1;
            for (int i = 0; i < 6; i++) begin
              if (sel_port == 3'(i + 1)) begin
                wr_q[i]   <= wr_in;
                addr_q[i] <= addr_in;
                if (wr_in) data_q[i] <= data_in;
              end
            end
          end else begin
            ready <= 1'b0;
          end
        end
        ACCESS: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Flat port view of the registered arrays.
  assign wr_out1   = wr_q[0];
  assign wr_out2   = wr_q[1];
  assign wr_out3   = wr_q[2];
  assign wr_out4   = wr_q[3];
  assign wr_out5   = wr_q[4];
  assign wr_out6   = wr_q[5];
  assign addr_out1 = addr_q[0];
  assign addr_out2 = addr_q[1];
  assign addr_out3 = addr_q[2];
  assign addr_out4 = addr_q[3];
  assign addr_out5 = addr_q[4];
  assign addr_out6 = addr_q[5];
  assign data_out1 = data_q[0];
  assign data_out2 = data_q[1];
  assign data_out3 = data_q[2];
  assign data_out4 = data_q[3];
  assign data_out5 = data_q[4];
  assign data_out6 = data_q[5];

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: directed scenarios plus random transfers, checked
// against a transaction-level model of the six ports.
module tb_apb_slave;

  logic        clk;
  logic        rst;
  logic        wr_in;
  logic        en;
  logic [2:0]  sel_port;
  logic [11:0] addr_in;
  logic [31:0] data_in;
  logic        ready;
  logic        wr_out1, wr_out2, wr_out3, wr_out4, wr_out5, wr_out6;
  logic [11:0] addr_out1, addr_out2, addr_out3, addr_out4, addr_out5, addr_out6;
  logic [31:0] data_out1, data_out2, data_out3, data_out4, data_out5, data_out6;

  int vectors;
  int miscompares;

  logic        m_wr   [1:6];
  logic [11:0] m_addr [1:6];
  logic [31:0] m_data [1:6];

  logic        wr_o   [1:6];
  logic [11:0] addr_o [1:6];
  logic [31:0] data_o [1:6];

  apb_slave dut (
    .clk(clk), .rst(rst), .wr_in(wr_in), .en(en), .sel_port(sel_port),
    .addr_in(addr_in), .data_in(data_in), .ready(ready),
    .wr_out1(wr_out1), .wr_out2(wr_out2), .wr_out3(wr_out3),
    .wr_out4(wr_out4), .wr_out5(wr_out5), .wr_out6(wr_out6),
    .addr_out1(addr_out1), .addr_out2(addr_out2), .addr_out3(addr_out3),
    .addr_out4(addr_out4), .addr_out5(addr_out5), .addr_out6(addr_out6),
    .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .data_out4(data_out4), .data_out5(data_out5), .data_out6(data_out6)
  );

  assign wr_o[1] = wr_out1;   assign wr_o[2] = wr_out2;   assign wr_o[3] = wr_out3;
  assign wr_o[4] = wr_out4;   assign wr_o[5] = wr_out5;   assign wr_o[6] = wr_out6;
  assign addr_o[1] = addr_out1; assign addr_o[2] = addr_out2; assign addr_o[3] = addr_out3;
  assign addr_o[4] = addr_out4; assign addr_o[5] = addr_out5; assign addr_o[6] = addr_out6;
  assign data_o[1] = data_out1; assign data_o[2] = data_out2; assign data_o[3] = data_out3;
  assign data_o[4] = data_out4; assign data_o[5] = data_out5; assign data_o[6] = data_out6;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 1; p <= 6; p++) begin
      m_wr[p] = 1'b0; m_addr[p] = 12'h000; m_data[p] = 32'h0;
    end
  endtask

  task automatic check_all(input string tag, input logic exp_ready);
    chk($sformatf("%s_ready", tag), 32'(ready), 32'(exp_ready));
    for (int p = 1; p <= 6; p++) begin
      chk($sformatf("%s_wr%0d", tag, p), 32'(wr_o[p]), 32'(m_wr[p]));
      chk($sformatf("%s_addr%0d", tag, p), 32'(addr_o[p]), 32'(m_addr[p]));
      chk($sformatf("%s_data%0d", tag, p), data_o[p], m_data[p]);
    end
  endtask

  // One transfer: drive in IDLE, check the ACCESS cycle (scrambling inputs and
  // optionally dropping en meanwhile), then check the return to IDLE.
  task automatic xfer(input string tag, input logic w, input logic [2:0] s,
                      input logic [11:0] a, input logic [31:0] d, input logic hold_en);
    @(negedge clk);
    wr_in = w; sel_port = s; addr_in = a; data_in = d; en = 1'b1;
    @(posedge clk); #1;
    if (s >= 3'd1 && s <= 3'd6) begin
      m_wr[s] = w;
      m_addr[s] = a;
      if (w) m_data[s] = d;
    end
    check_all({tag, "_acc"}, 1'b1);
    en = hold_en;
    wr_in = 1'($urandom); sel_port = 3'($urandom);
    addr_in = 12'($urandom); data_in = $urandom;
    #2 chk({tag, "_ready_hold"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    check_all({tag, "_idle"}, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_clear();
    rst = 1'b0; en = 1'b0; wr_in = 1'b0; sel_port = 3'd0;
    addr_in = 12'h0; data_in = 32'h0;

    #3 check_all("por", 1'b0);
    @(negedge clk); #2 rst = 1'b1;

    // write port 3
    xfer("wr3", 1'b1, 3'd3, 12'h300, 32'd13, 1'b0);

    // write then read port 5
    xfer("wr5", 1'b1, 3'd5, 12'h010, 32'hDEAD_BEEF, 1'b0);
    xfer("rd5", 1'b0, 3'd5, 12'h020, 32'h1234_5678, 1'b0);

    // invalid selects
    xfer("sel0", 1'b1, 3'd0, 12'hFFF, 32'hFFFF_FFFF, 1'b0);
    xfer("sel7", 1'b1, 3'd7, 12'hFFF, 32'hFFFF_FFFF, 1'b0);

    // back-to-back with en held high
    for (int n = 1; n <= 6; n++)
      xfer($sformatf("b2b%0d", n), 1'b1, 3'(n), 12'($urandom), 32'(n), 1'b1);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1 check_all("b2b_end", 1'b0);

    // reset mid-cycle while idle
    @(negedge clk); #2 rst = 1'b0;
    #1 model_clear();
    check_all("rst_idle", 1'b0);
    @(negedge clk); rst = 1'b1;

    // reset during ACCESS
    xfer("pre", 1'b1, 3'd2, 12'hABC, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    wr_in = 1'b1; sel_port = 3'd4; addr_in = 12'h444; data_in = 32'h4444_4444; en = 1'b1;
    @(posedge clk); #1;
    m_wr[4] = 1'b1; m_addr[4] = 12'h444; m_data[4] = 32'h4444_4444;
    check_all("acc_before_rst", 1'b1);
    #1 rst = 1'b0;
    #1 model_clear();
    check_all("rst_acc", 1'b0);
    en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 check_all("post_rst", 1'b0);

    // random transfers
    for (int k = 0; k < 40; k++)
      xfer($sformatf("rnd%0d", k), 1'($urandom), 3'($urandom), 12'($urandom),
           $urandom, 1'($urandom));
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1 check_all("rnd_end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
